// File: rtl/can_rx_frame.sv
// can_rx_frame
// Receive path for the CAN link. rx_i is sampled once per clk_can_i rising
// edge. The block detects SOF, removes stuff bits, assembles an extended
// (29-bit ID) frame, and checks stuffing, form and CRC-15. It drives the ACK
// slot and presents received frames with a one-cycle valid pulse.
//
// Optional feature macro: CAN_RX_ACK_EN
//   defined   : ack_o drives a dominant ACK for a frame whose CRC is good
//   undefined : ack_o is tied to 0 (listen-only)
//
// Ports
//   clk_can_i      in   bit-rate clock
//   rst_i          in   synchronous active-high reset
//   rx_i           in   bus level, 1 = recessive (already synchronized)
//   ack_o          out  1 = drive dominant during the ACK slot
//   rx_busy_o      out  high from the SOF sample until return to IDLE
//   frame_valid_o  out  one-cycle pulse, frame outputs updated
//   id_o           out  {ID_A[10:0], ID_B[17:0]}
//   rtr_o          out  received RTR bit
//   dlc_o          out  received DLC, raw
//   data_o         out  first byte in [63:56]; bytes not received are 0
//   err_o          out  one-cycle pulse on a frame error
//   err_code_o     out  01 stuff, 10 form, 11 CRC; held until the next err_o
//
// state     | meaning
// WAIT_IDLE | counting IDLE_BITS consecutive recessive bits
// IDLE      | bus idle, waiting for a dominant SOF
// ARB_A     | 11-bit base ID
// SRR_IDE   | SRR and IDE, both must be recessive
// ARB_B     | 18-bit ID extension
// CTRL      | RTR, r1, r0, DLC
// DATA      | data bytes
// CRC       | 15-bit received CRC
// CRC_DEL   | CRC delimiter (also absorbs a stuff bit after the CRC)
// ACK       | ACK slot
// ACK_DEL   | ACK delimiter, CRC verdict reported here
// EOF       | 7 recessive end-of-frame bits
module can_rx_frame #(
    parameter int IDLE_BITS = 11
) (
    input  logic        clk_can_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        ack_o,
    output logic        rx_busy_o,
    output logic        frame_valid_o,
    output logic [28:0] id_o,
    output logic        rtr_o,
    output logic [3:0]  dlc_o,
    output logic [63:0] data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);
    typedef enum logic [3:0] {
        WAIT_IDLE, IDLE, ARB_A, SRR_IDE, ARB_B, CTRL,
        DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF
    } state_t;

    localparam logic [14:0] CRC_POLY  = 15'h4599;
    localparam logic [1:0]  ERR_STUFF = 2'b01;
    localparam logic [1:0]  ERR_FORM  = 2'b10;
    localparam logic [1:0]  ERR_CRC   = 2'b11;

    state_t      state, state_n;
    logic [6:0]  bit_cnt, bit_cnt_n;
    logic [2:0]  run_cnt, run_cnt_n;
    logic        last_bit, last_bit_n;
    logic [28:0] id_sh, id_sh_n;
    logic        rtr_sh, rtr_sh_n;
    logic [3:0]  dlc_sh, dlc_sh_n;
    logic [63:0] data_sh, data_sh_n;
    logic [14:0] crc_reg, crc_reg_n;
    logic [14:0] crc_rx, crc_rx_n;
    logic        crc_ok, crc_ok_n;
    logic        valid_n, err_n;
    logic [1:0]  code_n;
    logic        destuff, stuff_bit;
    logic [3:0]  dlc_full;
    logic [6:0]  data_bits;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC_POLY : 15'h0000);
    endfunction

    // A stuff bit may follow the last CRC bit; it lands in CRC_DEL with the
    // run counter still at 5 and is absorbed there.
    assign destuff   = (state inside {ARB_A, SRR_IDE, ARB_B, CTRL, DATA, CRC}) ||
                       (state == CRC_DEL && run_cnt == 3'd5);
    assign stuff_bit = destuff && (run_cnt == 3'd5);
    assign dlc_full  = {dlc_sh[2:0], rx_i};
    // DLC above 8 still carries 8 bytes
    assign data_bits = dlc_sh[3] ? 7'd64 : {1'b0, dlc_sh[2:0], 3'b000};
    assign rx_busy_o = (state != IDLE) && (state != WAIT_IDLE);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        run_cnt_n  = run_cnt;
        last_bit_n = last_bit;
        id_sh_n    = id_sh;
        rtr_sh_n   = rtr_sh;
        dlc_sh_n   = dlc_sh;
        data_sh_n  = data_sh;
        crc_reg_n  = crc_reg;
        crc_rx_n   = crc_rx;
        crc_ok_n   = crc_ok;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        code_n     = err_code_o;

        if (stuff_bit) begin
            if (rx_i == last_bit) begin
                err_n  = 1'b1;
                code_n = ERR_STUFF;
            end else begin
                run_cnt_n  = 3'd1;
                last_bit_n = rx_i;
            end
        end else begin
            if (destuff) begin
                run_cnt_n  = (rx_i == last_bit) ? run_cnt + 3'd1 : 3'd1;
                last_bit_n = rx_i;
            end
            if (state inside {ARB_A, SRR_IDE, ARB_B, CTRL, DATA})
                crc_reg_n = crc_step(crc_reg, rx_i);
            bit_cnt_n = bit_cnt + 7'd1;

            case (state)
                WAIT_IDLE: begin
                    if (!rx_i) begin
                        bit_cnt_n = 7'd0;
                    end else if (bit_cnt == 7'(IDLE_BITS - 1)) begin
                        state_n   = IDLE;
                        bit_cnt_n = 7'd0;
                    end
                end
                IDLE: begin
                    bit_cnt_n = 7'd0;
                    if (!rx_i) begin
                        state_n    = ARB_A;
                        run_cnt_n  = 3'd1;
                        last_bit_n = 1'b0;
                        id_sh_n    = '0;
                        rtr_sh_n   = 1'b0;
                        dlc_sh_n   = '0;
                        data_sh_n  = '0;
                        crc_reg_n  = '0;
                        crc_rx_n   = '0;
                        crc_ok_n   = 1'b0;
                    end
                end
                ARB_A: begin
                    id_sh_n = {id_sh[27:0], rx_i};
                    if (bit_cnt == 7'd10) begin
                        state_n   = SRR_IDE;
                        bit_cnt_n = 7'd0;
                    end
                end
                SRR_IDE: begin
                    if (!rx_i) begin
                        err_n  = 1'b1;
                        code_n = ERR_FORM;
                    end else if (bit_cnt == 7'd1) begin
                        state_n   = ARB_B;
                        bit_cnt_n = 7'd0;
                    end
                end
                ARB_B: begin
                    id_sh_n = {id_sh[27:0], rx_i};
                    if (bit_cnt == 7'd17) begin
                        state_n   = CTRL;
                        bit_cnt_n = 7'd0;
                    end
                end
                CTRL: begin
                    if (bit_cnt == 7'd0)
                        rtr_sh_n = rx_i;
                    if (bit_cnt >= 7'd3)
                        dlc_sh_n = dlc_full;
                    if (bit_cnt == 7'd6) begin
                        bit_cnt_n = 7'd0;
                        state_n   = (rtr_sh || dlc_full == 4'd0) ? CRC : DATA;
                    end
                end
                DATA: begin
                    data_sh_n[6'd63 - bit_cnt[5:0]] = rx_i;
                    if (bit_cnt == data_bits - 7'd1) begin
                        state_n   = CRC;
                        bit_cnt_n = 7'd0;
                    end
                end
                CRC: begin
                    crc_rx_n = {crc_rx[13:0], rx_i};
                    if (bit_cnt == 7'd14) begin
                        crc_ok_n  = (crc_rx_n == crc_reg);
                        state_n   = CRC_DEL;
                        bit_cnt_n = 7'd0;
                    end
                end
                CRC_DEL: begin
                    if (!rx_i) begin
                        err_n  = 1'b1;
                        code_n = ERR_FORM;
                    end else begin
                        state_n = ACK;
                    end
                end
                ACK: state_n = ACK_DEL;
                ACK_DEL: begin
                    if (!rx_i) begin
                        err_n  = 1'b1;
                        code_n = ERR_FORM;
                    end else if (!crc_ok) begin
                        err_n  = 1'b1;
                        code_n = ERR_CRC;
                    end else begin
                        state_n   = EOF;
                        bit_cnt_n = 7'd0;
                    end
                end
                EOF: begin
                    if (!rx_i) begin
                        err_n  = 1'b1;
                        code_n = ERR_FORM;
                    end else if (bit_cnt == 7'd6) begin
                        valid_n   = 1'b1;
                        state_n   = IDLE;
                        bit_cnt_n = 7'd0;
                    end
                end
                default: state_n = WAIT_IDLE;
            endcase
        end

        if (err_n) begin
            state_n   = WAIT_IDLE;
            bit_cnt_n = 7'd0;
        end
    end

    always_ff @(posedge clk_can_i) begin
        if (rst_i) begin
            state         <= WAIT_IDLE;
            bit_cnt       <= '0;
            run_cnt       <= '0;
            last_bit      <= 1'b0;
            id_sh         <= '0;
            rtr_sh        <= 1'b0;
            dlc_sh        <= '0;
            data_sh       <= '0;
            crc_reg       <= '0;
            crc_rx        <= '0;
            crc_ok        <= 1'b0;
            frame_valid_o <= 1'b0;
            err_o         <= 1'b0;
            err_code_o    <= '0;
            id_o          <= '0;
            rtr_o         <= 1'b0;
            dlc_o         <= '0;
            data_o        <= '0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            run_cnt       <= run_cnt_n;
            last_bit      <= last_bit_n;
            id_sh         <= id_sh_n;
            rtr_sh        <= rtr_sh_n;
            dlc_sh        <= dlc_sh_n;
            data_sh       <= data_sh_n;
            crc_reg       <= crc_reg_n;
            crc_rx        <= crc_rx_n;
            crc_ok        <= crc_ok_n;
            frame_valid_o <= valid_n;
            err_o         <= err_n;
            err_code_o    <= code_n;
            if (valid_n) begin
                id_o   <= id_sh;
                rtr_o  <= rtr_sh;
                dlc_o  <= dlc_sh;
                data_o <= data_sh;
            end
        end
    end

`ifdef CAN_RX_ACK_EN
    logic ack_r;

    // High for exactly the ACK bit time: set on a good CRC_DEL sample (not a
    // trailing stuff bit), cleared when the ACK slot itself is sampled.
    always_ff @(posedge clk_can_i) begin
        if (rst_i)
            ack_r <= 1'b0;
        else if (state == CRC_DEL && run_cnt != 3'd5 && rx_i && crc_ok)
            ack_r <= 1'b1;
        else if (state == ACK)
            ack_r <= 1'b0;
    end

    assign ack_o = ack_r;
`else
    assign ack_o = 1'b0;
`endif

endmodule

// File: tb/tb_can_rx_frame.sv
// Bench for can_rx_frame: frames are built from their field list, CRC is the
// remainder of polynomial long division, then bit-stuffed; each bus sample is
// followed by a check of the per-cycle outputs and, at frame end, the payload.
module tb_can_rx_frame;
    logic        clk_can_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        ack_o, rx_busy_o, frame_valid_o, rtr_o, err_o;
    logic [28:0] id_o;
    logic [3:0]  dlc_o;
    logic [63:0] data_o;
    logic [1:0]  err_code_o;

    int total = 0;
    int bad   = 0;

`ifdef CAN_RX_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    can_rx_frame #(.IDLE_BITS(11)) dut (
        .clk_can_i     (clk_can_i),
        .rst_i         (rst_i),
        .rx_i          (rx_i),
        .ack_o         (ack_o),
        .rx_busy_o     (rx_busy_o),
        .frame_valid_o (frame_valid_o),
        .id_o          (id_o),
        .rtr_o         (rtr_o),
        .dlc_o         (dlc_o),
        .data_o        (data_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o)
    );

    always #5 clk_can_i = ~clk_can_i;

    // wire image of the current frame and landmarks within it
    bit          fr[$];
    int          first_stuff, crcdel_pos, ide_pos, data_pos;
    logic [28:0] f_id;
    logic        f_rtr;
    logic [3:0]  f_dlc;
    logic [63:0] f_data;
    logic [15:0] gen = 16'hC599;

    // expected held outputs
    logic [28:0] exp_id   = '0;
    logic        exp_rtr  = 1'b0;
    logic [3:0]  exp_dlc  = '0;
    logic [63:0] exp_data = '0;
    logic [1:0]  exp_code = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit b);
        rx_i = b;
        @(posedge clk_can_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            check("idle_valid", frame_valid_o, 1'b0);
            check("idle_err", err_o, 1'b0);
            check("idle_busy", rx_busy_o, 1'b0);
        end
    endtask

    task automatic build(input logic [28:0] id, input bit rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input bit ide, input int crc_flip);
        bit          raw[$];
        bit          a[$];
        int          pos[$];
        int          nb, run, nraw;
        bit          last;
        logic [14:0] crc;
        raw.push_back(1'b0);
        for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
        raw.push_back(1'b1);
        raw.push_back(ide);
        for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        f_data = '0;
        for (int i = 0; i < nb * 8; i++) begin
            raw.push_back(data[63 - i]);
            f_data[63 - i] = data[63 - i];
        end
        f_id = id; f_rtr = rtr; f_dlc = dlc;
        nraw = raw.size();
        a = raw;
        for (int i = 0; i < 15; i++) a.push_back(1'b0);
        for (int i = 0; i < nraw; i++)
            if (a[i])
                for (int j = 0; j < 16; j++) a[i + j] = a[i + j] ^ gen[15 - j];
        for (int j = 0; j < 15; j++) crc[14 - j] = a[nraw + j];
        if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);

        fr.delete();
        first_stuff = -1;
        run = 0; last = 1'b0;
        for (int i = 0; i < raw.size(); i++) begin
            pos.push_back(fr.size());
            fr.push_back(raw[i]);
            run = (i > 0 && raw[i] == last) ? run + 1 : 1;
            last = raw[i];
            if (run == 5) begin
                if (first_stuff < 0) first_stuff = fr.size();
                fr.push_back(!last);
                last = !last;
                run = 1;
            end
        end
        ide_pos    = pos[13];
        data_pos   = (nb > 0) ? pos[39] : -1;
        crcdel_pos = fr.size();
        for (int i = 0; i < 10; i++) fr.push_back(1'b1);
    endtask

    // err_at < 0: good frame expected; otherwise error pulse at that sample
    task automatic run_frame(input string name, input int err_at, input logic [1:0] code,
                             input bit crc_good);
        int stop;
        stop = (err_at >= 0) ? err_at : fr.size() - 1;
        for (int k = 0; k <= stop; k++) begin
            tick(fr[k]);
            check({name, "_busy"}, rx_busy_o, k != stop);
            check({name, "_valid"}, frame_valid_o, err_at < 0 && k == stop);
            check({name, "_err"}, err_o, err_at >= 0 && k == stop);
            check({name, "_ack"}, ack_o, ACK_EN && crc_good && k == crcdel_pos);
        end
        if (err_at < 0) begin
            exp_id = f_id; exp_rtr = f_rtr; exp_dlc = f_dlc; exp_data = f_data;
        end else begin
            exp_code = code;
        end
        check({name, "_id"}, id_o, exp_id);
        check({name, "_rtr"}, rtr_o, exp_rtr);
        check({name, "_dlc"}, dlc_o, exp_dlc);
        check({name, "_data"}, data_o, exp_data);
        check({name, "_code"}, err_code_o, exp_code);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"}, ack_o, 1'b0);
        check({name, "_busy"}, rx_busy_o, 1'b0);
        check({name, "_valid"}, frame_valid_o, 1'b0);
        check({name, "_err"}, err_o, 1'b0);
        check({name, "_id"}, id_o, 29'd0);
        check({name, "_rtr"}, rtr_o, 1'b0);
        check({name, "_dlc"}, dlc_o, 4'd0);
        check({name, "_data"}, data_o, 64'd0);
        check({name, "_code"}, err_code_o, 2'd0);
    endtask

    initial begin
        int kind, gap;
        logic [28:0] rid;
        logic [63:0] rdata;

        rst_i = 1'b1;
        rx_i  = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check_all_zero("reset");
        rst_i = 1'b0;

        idle(11);
        build(29'h1ABCDE01, 1'b0, 4'd8, 64'h3132333435363738, 1'b1, -1);
        run_frame("plan", -1, 2'b00, 1'b1);

        build(29'h0F0F0F0F, 1'b0, 4'd2, 64'hA55A_1234_5678_9ABC, 1'b1, -1);
        run_frame("dlc2", -1, 2'b00, 1'b1);
        check("dlc2_data_const", data_o, 64'hA55A000000000000);

        // six dominant bits in ID_A, then prove 10 recessive bits are not enough
        build(29'h00012345, 1'b0, 4'd1, 64'h77 << 56, 1'b1, -1);
        fr[first_stuff] = ~fr[first_stuff];
        run_frame("stuff", first_stuff, 2'b01, 1'b1);
        idle(10);
        tick(1'b0);
        check("stuff_wait_busy", rx_busy_o, 1'b0);
        idle(11);
        build(29'h15555555, 1'b0, 4'd3, 64'hDEADBE00_00000000, 1'b1, -1);
        run_frame("after_stuff", -1, 2'b00, 1'b1);

        build(29'h0ABCDEF1, 1'b0, 4'd4, 64'h01020304_00000000, 1'b1, 3);
        run_frame("crc", crcdel_pos + 2, 2'b11, 1'b0);
        idle(11);

        build(29'h12345678, 1'b0, 4'd1, 64'h5500000000000000, 1'b0, -1);
        run_frame("ide0", ide_pos, 2'b10, 1'b1);
        idle(11);

        build(29'h0000FFFF, 1'b1, 4'd5, 64'h0, 1'b1, -1);
        fr[crcdel_pos + 6] = 1'b0;
        run_frame("eof4", crcdel_pos + 6, 2'b10, 1'b1);
        idle(11);

        // reset in the middle of DATA
        build(29'h1F00F00F, 1'b0, 4'd8, 64'hFEDCBA9876543210, 1'b1, -1);
        for (int k = 0; k <= data_pos + 10; k++) tick(fr[k]);
        check("mid_busy", rx_busy_o, 1'b1);
        rst_i = 1'b1;
        tick(1'b1);
        rst_i = 1'b0;
        check_all_zero("midrst");
        exp_id = '0; exp_rtr = 1'b0; exp_dlc = '0; exp_data = '0; exp_code = '0;
        tick(1'b0);
        check("midrst_wait_busy", rx_busy_o, 1'b0);
        idle(11);
        build(29'h03C3C3C3, 1'b0, 4'd7, 64'h0102030405060708, 1'b1, -1);
        run_frame("after_rst", -1, 2'b00, 1'b1);

        for (int n = 0; n < 30; n++) begin
            kind  = $urandom_range(0, 5);
            rid   = 29'($urandom);
            rdata = {$urandom, $urandom};
            case (kind)
                2: begin
                    build(rid, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), rdata,
                          1'b1, $urandom_range(0, 14));
                    run_frame("r_crc", crcdel_pos + 2, 2'b11, 1'b0);
                    idle(11);
                end
                3: begin
                    build(rid, 1'b0, 4'($urandom_range(0, 15)), rdata, 1'b0, -1);
                    run_frame("r_ide", ide_pos, 2'b10, 1'b1);
                    idle(11);
                end
                4: begin
                    build(rid, 1'b0, 4'($urandom_range(0, 15)), rdata, 1'b1, -1);
                    fr[crcdel_pos + 6] = 1'b0;
                    run_frame("r_eof", crcdel_pos + 6, 2'b10, 1'b1);
                    idle(11);
                end
                5: begin
                    build(rid & 29'h01FFFFFF, 1'b0, 4'($urandom_range(0, 15)), rdata, 1'b1, -1);
                    fr[first_stuff] = ~fr[first_stuff];
                    run_frame("r_stuff", first_stuff, 2'b01, 1'b1);
                    idle(11);
                end
                default: begin
                    build(rid, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), rdata,
                          1'b1, -1);
                    run_frame("r_good", -1, 2'b00, 1'b1);
                    gap = $urandom_range(0, 2);
                    idle(gap);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
